// File: rtl/mini_tpu_pkg.sv
// Shared types and constants for the mini TPU result reader slice.
package mini_tpu_pkg;

  localparam int DEPTH   = 8;
  localparam int RES_W   = 64;
  localparam int HOST_W  = 32;
  localparam int HOST_AW = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READY   = 2'd2
  } state_e;

endpackage

// File: rtl/mini_tpu_result_reader_if.sv
// Core result stream, host read port and status signals of the result reader.
interface mini_tpu_result_reader_if #(
  parameter int RES_W = mini_tpu_pkg::RES_W
);
  import mini_tpu_pkg::*;

  logic               start;
  logic               res_valid;
  logic [RES_W-1:0]   res_data;
  logic               core_done;
  logic               re;
  logic [HOST_AW-1:0] read_addr;
  logic [HOST_W-1:0]  read_data;
  logic               read_valid;
  logic               results_ready;
  logic [HOST_AW-1:0] entry_count;
  logic               overflow;

  // Master drives the core and host side; slave is the reader itself.
  modport master (
    output start, res_valid, res_data, core_done, re, read_addr,
    input  read_data, read_valid, results_ready, entry_count, overflow
  );

  modport slave (
    input  start, res_valid, res_data, core_done, re, read_addr,
    output read_data, read_valid, results_ready, entry_count, overflow
  );

endinterface

// File: rtl/result_buffer.sv
// DEPTH x RES_W register file with one synchronous write port and one registered read port.
module result_buffer #(
  parameter int DEPTH = 8,
  parameter int RES_W = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [RES_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [RES_W-1:0] rd_data
);

  logic [RES_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; stale contents are hidden by entry_count upstream.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mini_tpu_result_reader.sv
// Captures the core's result entries after start and serves them to the host as 32-bit words.
module mini_tpu_result_reader #(
  parameter int DEPTH = mini_tpu_pkg::DEPTH,
  parameter int RES_W = mini_tpu_pkg::RES_W
) (
  input logic                     clk,
  input logic                     rst,
  mini_tpu_result_reader_if.slave bus
);
  import mini_tpu_pkg::*;

  localparam int                 AW   = $clog2(DEPTH);
  localparam logic [HOST_AW-1:0] FULL = HOST_AW'(DEPTH);

  state_e             state;
  logic [HOST_AW-1:0] entry_count;
  logic               overflow;
  logic               rd_pending;
  logic               rd_half;
  logic               rd_zero;
  logic               wr_en;
  logic               rd_en;
  logic [RES_W-1:0]   rd_word;

  // start always wins over a same-cycle entry or read; rst wins over everything.
  assign wr_en = !rst && !bus.start && (state == CAPTURE) && bus.res_valid
                 && (entry_count < FULL);
  assign rd_en = !rst && !bus.start && (state == READY) && bus.re;

  result_buffer #(
    .DEPTH (DEPTH),
    .RES_W (RES_W),
    .AW    (AW)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (entry_count[AW-1:0]),
    .wr_data (bus.res_data),
    .rd_en   (rd_en),
    .rd_addr (bus.read_addr[AW:1]),
    .rd_data (rd_word)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      entry_count <= '0;
      overflow    <= 1'b0;
      rd_pending  <= 1'b0;
      rd_half     <= 1'b0;
      rd_zero     <= 1'b0;
    end else begin
      rd_pending <= rd_en;
      rd_half    <= bus.read_addr[0];
      rd_zero    <= {1'b0, bus.read_addr[HOST_AW-1:1]} >= entry_count;

      if (bus.start) begin
        state       <= CAPTURE;
        entry_count <= '0;
        overflow    <= 1'b0;
      end else if (state == CAPTURE) begin
        if (bus.res_valid) begin
          if (entry_count < FULL) entry_count <= entry_count + 1'b1;
          else                    overflow    <= 1'b1;
        end
        if (bus.core_done) state <= READY;
      end
    end
  end

  assign bus.read_valid    = rd_pending;
  assign bus.read_data     = (!rd_pending || rd_zero) ? '0 :
                             rd_half ? rd_word[2*HOST_W-1:HOST_W] : rd_word[HOST_W-1:0];
  assign bus.results_ready = (state == READY);
  assign bus.entry_count   = entry_count;
  assign bus.overflow      = overflow;

endmodule

// File: tb/tb_mini_tpu_result_reader.sv
// Self-checking bench: directed scenarios plus a randomized run against a queue-based model.
module tb_mini_tpu_result_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mini_tpu_result_reader_if bus ();

  mini_tpu_result_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model: captured entries as a queue, a phase flag and the expected read response.
  localparam int P_IDLE = 0, P_CAP = 1, P_READY = 2;
  int          m_phase = P_IDLE;
  logic [63:0] m_q[$];
  logic        m_ovf   = 1'b0;
  logic        exp_rv  = 1'b0;
  logic [31:0] exp_rd  = '0;

  function automatic logic [31:0] model_word(input logic [3:0] a);
    int idx;
    idx = int'(a) / 2;
    if (idx >= m_q.size()) return 32'h0;
    return (a % 2 == 1) ? m_q[idx][63:32] : m_q[idx][31:0];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_phase = P_IDLE;
      m_q.delete();
      m_ovf  = 1'b0;
      exp_rv = 1'b0;
      exp_rd = '0;
    end else begin
      exp_rv = (m_phase == P_READY) && bus.re && !bus.start;
      exp_rd = exp_rv ? model_word(bus.read_addr) : 32'h0;
      if (bus.start) begin
        m_phase = P_CAP;
        m_q.delete();
        m_ovf = 1'b0;
      end else if (m_phase == P_CAP) begin
        if (bus.res_valid) begin
          if (m_q.size() < 8) m_q.push_back(bus.res_data);
          else                m_ovf = 1'b1;
        end
        if (bus.core_done) m_phase = P_READY;
      end
    end
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, settle 1 ns.
  task automatic step(input bit st, input bit rv, input logic [63:0] d, input bit dn,
                      input bit r, input logic [3:0] a, input bit rs = 1'b0);
    @(negedge clk);
    rst           = rs;
    bus.start     = st;
    bus.res_valid = rv;
    bus.res_data  = d;
    bus.core_done = dn;
    bus.re        = r;
    bus.read_addr = a;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_step();
    step(0, 0, 64'h0, 0, 0, 4'h0);
  endtask

  task automatic test_reset();
    step(1, 1, 64'h5555, 1, 1, 4'h3, 1);
    step(0, 1, 64'h7777, 0, 1, 4'h0, 1);
    checks += 4;
    if (bus.results_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", bus.results_ready); end
    if (bus.entry_count !== 4'd0)   begin failures++; $display("FAIL reset_count: got %0d want 0", bus.entry_count); end
    if (bus.overflow !== 1'b0)      begin failures++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    if (bus.read_valid !== 1'b0 || bus.read_data !== 32'h0) begin
      failures++; $display("FAIL reset_read: got rv=%b data=%h want rv=0 data=0", bus.read_valid, bus.read_data);
    end
    idle_step();
  endtask

  task automatic test_basic_capture();
    logic [63:0] vals [4];
    logic [31:0] want [4];
    vals = '{64'h1, 64'h100, 64'h10000, 64'h1000000};
    want = '{32'h1, 32'h100, 32'h10000, 32'h1000000};
    step(1, 0, 64'h0, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) step(0, 1, vals[i], 0, 0, 4'h0);
    step(0, 0, 64'h0, 1, 0, 4'h0);
    checks += 2;
    if (bus.results_ready !== 1'b1) begin failures++; $display("FAIL basic_ready: got %b want 1", bus.results_ready); end
    if (bus.entry_count !== 4'd4)   begin failures++; $display("FAIL basic_count: got %0d want 4", bus.entry_count); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 64'h0, 0, 1, 4'(2 * i));
      checks++;
      if (bus.read_valid !== 1'b1 || bus.read_data !== want[i]) begin
        failures++; $display("FAIL basic_read%0d: got rv=%b data=%h want rv=1 data=%h", i, bus.read_valid, bus.read_data, want[i]);
      end
    end
    idle_step();
    checks++;
    if (bus.read_valid !== 1'b0) begin failures++; $display("FAIL basic_rv_idle: got %b want 0", bus.read_valid); end
  endtask

  task automatic test_halves_back_to_back();
    logic [3:0]  addrs [3];
    logic [31:0] want  [3];
    addrs = '{4'd0, 4'd1, 4'd9};
    want  = '{32'hCAFEF00D, 32'hDEADBEEF, 32'h0};
    step(1, 0, 64'h0, 0, 0, 4'h0);
    step(0, 1, 64'hDEADBEEF_CAFEF00D, 1, 0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 64'h0, 0, 1, addrs[i]);
      checks++;
      if (bus.read_valid !== 1'b1 || bus.read_data !== want[i]) begin
        failures++; $display("FAIL half_addr%0d: got rv=%b data=%h want rv=1 data=%h", addrs[i], bus.read_valid, bus.read_data, want[i]);
      end
    end
    idle_step();
  endtask

  task automatic test_overflow();
    step(1, 0, 64'h0, 0, 0, 4'h0);
    for (int i = 0; i < 9; i++) step(0, 1, 64'h100 + 64'(i), 0, 0, 4'h0);
    checks += 2;
    if (bus.entry_count !== 4'd8) begin failures++; $display("FAIL ovf_count: got %0d want 8", bus.entry_count); end
    if (bus.overflow !== 1'b1)    begin failures++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    step(0, 0, 64'h0, 1, 0, 4'h0);
    step(0, 0, 64'h0, 0, 1, 4'd14);
    checks++;
    if (bus.read_valid !== 1'b1 || bus.read_data !== 32'h107) begin
      failures++; $display("FAIL ovf_entry7: got rv=%b data=%h want rv=1 data=00000107", bus.read_valid, bus.read_data);
    end
    step(1, 0, 64'h0, 0, 0, 4'h0);
    checks += 2;
    if (bus.entry_count !== 4'd0) begin failures++; $display("FAIL ovf_restart_count: got %0d want 0", bus.entry_count); end
    if (bus.overflow !== 1'b0)    begin failures++; $display("FAIL ovf_restart_flag: got %b want 0", bus.overflow); end
  endtask

  task automatic test_done_with_entry();
    step(1, 1, 64'hAAAA, 0, 0, 4'h0);
    checks++;
    if (bus.entry_count !== 4'd0) begin failures++; $display("FAIL start_wins_count: got %0d want 0", bus.entry_count); end
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 64'h30 + 64'(i), 0, 1, 4'h0);
      checks++;
      if (bus.read_valid !== 1'b0 || bus.read_data !== 32'h0) begin
        failures++; $display("FAIL capture_re%0d: got rv=%b data=%h want rv=0 data=0", i, bus.read_valid, bus.read_data);
      end
    end
    step(0, 1, 64'h32, 1, 1, 4'h0);
    checks += 3;
    if (bus.entry_count !== 4'd3)   begin failures++; $display("FAIL done_count: got %0d want 3", bus.entry_count); end
    if (bus.results_ready !== 1'b1) begin failures++; $display("FAIL done_ready: got %b want 1", bus.results_ready); end
    if (bus.read_valid !== 1'b0)    begin failures++; $display("FAIL done_rv: got %b want 0", bus.read_valid); end
    step(0, 0, 64'h0, 0, 1, 4'd4);
    checks++;
    if (bus.read_valid !== 1'b1 || bus.read_data !== 32'h32) begin
      failures++; $display("FAIL done_entry2: got rv=%b data=%h want rv=1 data=00000032", bus.read_valid, bus.read_data);
    end
  endtask

  task automatic test_rst_mid_read();
    step(0, 0, 64'h0, 0, 1, 4'h0);
    step(0, 0, 64'h0, 0, 0, 4'h0, 1);
    checks += 3;
    if (bus.read_valid !== 1'b0 || bus.read_data !== 32'h0) begin
      failures++; $display("FAIL rst_read: got rv=%b data=%h want rv=0 data=0", bus.read_valid, bus.read_data);
    end
    if (bus.results_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", bus.results_ready); end
    if (bus.entry_count !== 4'd0)   begin failures++; $display("FAIL rst_count: got %0d want 0", bus.entry_count); end
    step(0, 1, 64'h99, 1, 0, 4'h0);
    checks++;
    if (bus.entry_count !== 4'd0 || bus.results_ready !== 1'b0) begin
      failures++; $display("FAIL idle_ignore: got count=%0d ready=%b want count=0 ready=0", bus.entry_count, bus.results_ready);
    end
  endtask

  task automatic test_start_with_read();
    step(1, 0, 64'h0, 0, 0, 4'h0);
    step(0, 1, 64'h44, 1, 0, 4'h0);
    step(1, 0, 64'h0, 0, 1, 4'h0);
    checks += 2;
    if (bus.read_valid !== 1'b0) begin failures++; $display("FAIL start_re_rv: got %b want 0", bus.read_valid); end
    if (bus.entry_count !== 4'd0 || bus.results_ready !== 1'b0) begin
      failures++; $display("FAIL start_re_state: got count=%0d ready=%b want count=0 ready=0", bus.entry_count, bus.results_ready);
    end
    step(0, 0, 64'h0, 0, 1, 4'h0);
    checks++;
    if (bus.read_valid !== 1'b0) begin failures++; $display("FAIL start_re_capture: got %b want 0", bus.read_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 12) == 0, $urandom % 2, {$urandom, $urandom}, ($urandom % 9) == 0,
           $urandom % 2, 4'($urandom % 16), ($urandom % 60) == 0);
      checks++;
      if (bus.read_valid !== exp_rv || bus.read_data !== exp_rd
          || bus.results_ready !== (m_phase == P_READY)
          || bus.entry_count !== 4'(m_q.size()) || bus.overflow !== m_ovf) begin
        failures++;
        $display("FAIL rand_cycle%0d: got rv=%b data=%h rdy=%b cnt=%0d ovf=%b want rv=%b data=%h rdy=%b cnt=%0d ovf=%b",
                 n, bus.read_valid, bus.read_data, bus.results_ready, bus.entry_count, bus.overflow,
                 exp_rv, exp_rd, m_phase == P_READY, m_q.size(), m_ovf);
      end
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.core_done = 1'b0;
    bus.re        = 1'b0;
    bus.read_addr = '0;
    test_reset();
    test_basic_capture();
    test_halves_back_to_back();
    test_overflow();
    test_done_with_entry();
    test_rst_mid_read();
    test_start_with_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mini_tpu_result_reader.md
MINI_TPU_RESULT_READER -- requirements
Module: mini_tpu_result_reader

Interface
REQ-001 Parameter DEPTH, default 8; number of 64-bit result entries held.
REQ-002 Parameter RES_W, default 64; width of one core result entry.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse, same pulse that launches the core; arms capture.
REQ-006 res_valid  input  1  core presents a result entry this cycle.
REQ-007 res_data  input  RES_W  result entry, the final_out value from the core.
REQ-008 core_done  input  1  core finished; no further entries follow.
REQ-009 re  input  1  host read strobe.
REQ-010 read_addr  input  4  host word address; bits [3:1] select the entry, bit [0] selects the half (0 = [31:0], 1 = [63:32]).
REQ-011 read_data  output  32  returned word.
REQ-012 read_valid  output  1  read_data valid this cycle.
REQ-013 results_ready  output  1  buffer complete and readable.
REQ-014 entry_count  output  4  entries captured, 0..DEPTH.
REQ-015 overflow  output  1  sticky; an entry arrived while the buffer was full.

Function
REQ-016 FSM states: IDLE, CAPTURE, READY.
REQ-017 IDLE -> CAPTURE on start; CAPTURE -> READY on core_done; READY -> CAPTURE on start.
REQ-018 Entering CAPTURE clears entry_count, write pointer, overflow, results_ready on the same edge.
REQ-019 In CAPTURE, res_valid with entry_count < DEPTH writes res_data to entry[entry_count] and increments entry_count by 1.
REQ-020 res_valid with entry_count == DEPTH: data dropped, overflow set to 1, entry_count holds at DEPTH.
REQ-021 res_valid and core_done in the same CAPTURE cycle: entry captured first (REQ-019/020 apply), then transition to READY.
REQ-022 res_valid or core_done in IDLE or READY: ignored, no state change.
REQ-023 start while in CAPTURE restarts capture per REQ-018; the partial set is discarded.
REQ-024 start and res_valid in the same cycle: start wins; the entry is not captured.
REQ-025 results_ready is 1 exactly while in READY.
REQ-026 Read latency is 1 cycle: re accepted at edge N drives read_valid = 1 and read_data for the cycle after N; read_valid is 0 in every other cycle.
REQ-027 re is honoured only in READY; in IDLE or CAPTURE re gives read_valid = 0 and read_data = 0.
REQ-028 Read of an entry index >= entry_count returns read_data = 32'h0 with read_valid = 1.
REQ-029 Back-to-back re on consecutive cycles returns one word per cycle, no bubbles.
REQ-030 re in the same cycle as a READY -> CAPTURE start is dropped (read_valid = 0 next cycle).
REQ-031 Buffer contents are not cleared on start or rst; visibility is governed by entry_count only.

Reset
REQ-032 rst forces state IDLE, entry_count 0, overflow 0, results_ready 0, read_valid 0, read_data 0 on the next edge.
REQ-033 rst overrides all other inputs, including mid-capture and mid-read; an in-flight read response is dropped.

Structure
REQ-034 Shared package mini_tpu_pkg holds the FSM state enum and the constants DEPTH, RES_W, HOST_W = 32, and HOST_AW = 4.
REQ-035 Storage is a sub-module result_buffer: DEPTH x RES_W register file, one synchronous write port, one registered read port.
REQ-036 The FSM, counters, half-select, and read_valid pipeline reside in mini_tpu_result_reader.

Verification
REQ-037 Reset, start, four res_valid entries 64'h1, 64'h100, 64'h10000, 64'h1000000, then core_done -> results_ready = 1, entry_count = 4; reads at addr 0, 2, 4, 6 return 1, 32'h100, 32'h10000, 32'h1000000, one cycle after each re.
REQ-038 Entry 64'hDEADBEEF_CAFEF00D at entry 0 -> addr 0 returns 32'hCAFEF00D, addr 1 returns 32'hDEADBEEF; addr 9 (entry 4 >= count 1) returns 32'h0 with read_valid = 1.
REQ-039 Nine res_valid pulses in CAPTURE -> entry_count = 8, overflow = 1, entry 7 holds the eighth value; a following start clears overflow and entry_count to 0.
REQ-040 res_valid with core_done in the same cycle as the third entry -> entry_count = 3 and READY next cycle; re asserted during CAPTURE -> read_valid stays 0.
REQ-041 rst asserted in the cycle after re in READY -> read_valid = 0 and read_data = 0 the next cycle, state IDLE, results_ready = 0.
REQ-042 start pulsed in READY with re high on the same cycle -> no read response; state CAPTURE, entry_count = 0 next cycle.
